// File: rtl/video_pkg.sv
// Shared video types and helpers: Bayer CFA phases, RGB565 field positions,
// remosaic FSM states and the dither LFSR step function.
package video_pkg;

    typedef enum logic [1:0] {
        PH_GR = 2'd0,
        PH_R  = 2'd1,
        PH_B  = 2'd2,
        PH_GB = 2'd3
    } bayer_phase_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } remosaic_state_t;

    localparam int RGB_R_MSB = 15;
    localparam int RGB_R_LSB = 11;
    localparam int RGB_G_MSB = 10;
    localparam int RGB_G_LSB = 5;
    localparam int RGB_B_MSB = 4;
    localparam int RGB_B_LSB = 0;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Right-shifting Galois LFSR: the bit shifted out folds the taps back in.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/bayer_remosaic_if.sv
// Pixel stream bundle for bayer_remosaic: RGB565 input side and raw Bayer output side.
interface bayer_remosaic_if;
    logic        sof_in;
    logic [15:0] pixel_in_data;
    logic        pixel_in_valid;
    logic [9:0]  pixel_out_data;
    logic        pixel_out_valid;
    logic        sof_out;
    logic        eol_out;
    logic        eof_out;
    logic        frame_err;

    modport master (
        output sof_in, pixel_in_data, pixel_in_valid,
        input  pixel_out_data, pixel_out_valid, sof_out, eol_out, eof_out, frame_err
    );

    modport slave (
        input  sof_in, pixel_in_data, pixel_in_valid,
        output pixel_out_data, pixel_out_valid, sof_out, eol_out, eof_out, frame_err
    );
endinterface

// File: rtl/rgb565_expand.sv
// Combinational RGB565 -> 10-bit Bayer sample for one CFA phase; the low bits are
// either replicated from the MSBs or taken from dither_i when DITHER is set.
module rgb565_expand
    import video_pkg::*;
#(
    parameter bit DITHER = 1'b0
) (
    input  logic [15:0]  rgb_i,
    input  bayer_phase_t phase_i,
    input  logic [4:0]   dither_i,
    output logic [9:0]   sample_o
);

    logic [4:0] r5_s;
    logic [5:0] g6_s;
    logic [4:0] b5_s;

    // Select the colour for this phase and fill the low bits.
    always_comb begin
        r5_s = rgb_i[RGB_R_MSB:RGB_R_LSB];
        g6_s = rgb_i[RGB_G_MSB:RGB_G_LSB];
        b5_s = rgb_i[RGB_B_MSB:RGB_B_LSB];
        case (phase_i)
            PH_R:    sample_o = {r5_s, (DITHER ? dither_i : r5_s)};
            PH_B:    sample_o = {b5_s, (DITHER ? dither_i : b5_s)};
            default: sample_o = {g6_s, (DITHER ? dither_i[3:0] : g6_s[5:2])};
        endcase
    end

endmodule

// File: rtl/bayer_remosaic.sv
// RGB565 -> 10-bit raw Bayer remosaic with frame tracking and a 2-stage pipe.
// Optional LFSR dither of the low bits is enabled by defining BAYER_REMOSAIC_DITHER_EN.
module bayer_remosaic
    import video_pkg::*;
#(
    parameter int          LINE_LENGTH = 2304,
    parameter int          NUM_LINES   = 1536,
    parameter logic [1:0]  FIRST_PHASE = 2'd0
) (
    input  logic            clk,
    input  logic            reset_n,
    bayer_remosaic_if.slave bus
);

    localparam int XW = $clog2(LINE_LENGTH);
    localparam int YW = $clog2(NUM_LINES);

    remosaic_state_t state_q, state_d;
    logic [XW-1:0]   x_q, x_d, cur_x_s;
    logic [YW-1:0]   y_q, y_d, cur_y_s;
    logic            acc_sof_s, acc_s, eol_s, eof_s;
    bayer_phase_t    phase_s;
    logic [9:0]      sample_s;
    logic [4:0]      dither_s;

    logic            s1_valid_q, s1_valid_d, s1_sof_q, s1_sof_d;
    logic            s1_eol_q, s1_eol_d, s1_eof_q, s1_eof_d;
    logic [9:0]      s1_data_q, s1_data_d;
    logic            out_valid_q, out_sof_q, out_eol_q, out_eof_q, err_q, err_d;
    logic [9:0]      out_data_q;

`ifdef BAYER_REMOSAIC_DITHER_EN
    localparam bit DITHER_ON = 1'b1;
    logic [15:0] lfsr_q, lfsr_d, lfsr_cur_s;

    // A start of frame reseeds first so every frame sees the same dither sequence.
    always_comb begin
        lfsr_cur_s = acc_sof_s ? LFSR_SEED : lfsr_q;
        if (bus.pixel_in_valid) begin
            lfsr_d = lfsr_step(lfsr_cur_s);
        end else begin
            lfsr_d = lfsr_q;
        end
        dither_s = lfsr_cur_s[4:0];
    end

    // Dither LFSR state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    localparam bit DITHER_ON = 1'b0;
    assign dither_s = 5'd0;
`endif

    // Pixel acceptance and the position this pixel occupies in the frame.
    always_comb begin
        acc_sof_s = bus.pixel_in_valid & bus.sof_in;
        acc_s     = bus.pixel_in_valid & (bus.sof_in | (state_q == ACTIVE));
        cur_x_s   = acc_sof_s ? {XW{1'b0}} : x_q;
        cur_y_s   = acc_sof_s ? {YW{1'b0}} : y_q;
        eol_s     = (cur_x_s == XW'(LINE_LENGTH - 1));
        eof_s     = eol_s & (cur_y_s == YW'(NUM_LINES - 1));
        phase_s   = bayer_phase_t'(FIRST_PHASE ^ {cur_y_s[0], cur_x_s[0]});
    end

    rgb565_expand #(.DITHER(DITHER_ON)) u_expand (
        .rgb_i    (bus.pixel_in_data),
        .phase_i  (phase_s),
        .dither_i (dither_s),
        .sample_o (sample_s)
    );

    // Next state, counters, error pulse and stage-1 contents.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        case (state_q)
            IDLE, DONE: begin
                if (acc_sof_s) state_d = eof_s ? DONE : ACTIVE;
                else           state_d = state_q;
            end
            ACTIVE: begin
                if (acc_s && eof_s) state_d = DONE;
                else                state_d = ACTIVE;
            end
            default: state_d = IDLE;
        endcase
        if (acc_s) begin
            if (eol_s) begin
                x_d = {XW{1'b0}};
                y_d = eof_s ? {YW{1'b0}} : (cur_y_s + YW'(1));
            end else begin
                x_d = cur_x_s + XW'(1);
                y_d = cur_y_s;
            end
        end else begin
            x_d = x_q;
            y_d = y_q;
        end
        // Restart over a live frame, or a pixel arriving outside any frame.
        err_d = (acc_sof_s & (state_q == ACTIVE))
              | (bus.pixel_in_valid & ~bus.sof_in & (state_q != ACTIVE));
        s1_valid_d = acc_s;
        s1_data_d  = acc_s ? sample_s : 10'd0;
        s1_sof_d   = acc_sof_s;
        s1_eol_d   = acc_s & eol_s;
        s1_eof_d   = acc_s & eof_s;
    end

    // State, counters and both pipeline stages.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            x_q         <= {XW{1'b0}};
            y_q         <= {YW{1'b0}};
            s1_valid_q  <= 1'b0;
            s1_data_q   <= 10'd0;
            s1_sof_q    <= 1'b0;
            s1_eol_q    <= 1'b0;
            s1_eof_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 10'd0;
            out_sof_q   <= 1'b0;
            out_eol_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_sof_q    <= s1_sof_d;
            s1_eol_q    <= s1_eol_d;
            s1_eof_q    <= s1_eof_d;
            out_valid_q <= s1_valid_q;
            out_data_q  <= s1_data_q;
            out_sof_q   <= s1_sof_q;
            out_eol_q   <= s1_eol_q;
            out_eof_q   <= s1_eof_q;
            err_q       <= err_d;
        end
    end

    assign bus.pixel_out_valid = out_valid_q;
    assign bus.pixel_out_data  = out_data_q;
    assign bus.sof_out         = out_sof_q;
    assign bus.eol_out         = out_eol_q;
    assign bus.eof_out         = out_eof_q;
    assign bus.frame_err       = err_q;

endmodule

// File: tb/tb_bayer_remosaic.sv
// Directed bench for bayer_remosaic on an 8x4 frame; the dither scenario runs only
// when BAYER_REMOSAIC_DITHER_EN is defined, the replication scenarios otherwise.
module tb_bayer_remosaic;

    typedef struct packed {
        logic       v;
        logic [9:0] d;
        logic       s;
        logic       e;
        logic       f;
    } exp_t;

    localparam exp_t NONE = '0;

    logic clk = 1'b0;
    logic reset_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_out   = 0;
    int   base;
    logic chk_data = 1'b1;
    exp_t pend = '0;
    exp_t e0;
    logic [9:0] cap[$];
    logic [9:0] seq_a[$];

    always #5 clk = ~clk;

    bayer_remosaic_if bus ();

    bayer_remosaic #(
        .LINE_LENGTH (8),
        .NUM_LINES   (4),
        .FIRST_PHASE (2'd0)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Independent G/R/B expansion for FIRST_PHASE=0.
    function automatic logic [9:0] ref_px(input logic [15:0] c, input int x, input int y);
        logic [1:0] ph;
        ph = {y[0], x[0]};
        case (ph)
            2'd1:    return {c[15:11], c[15:11]};
            2'd2:    return {c[4:0], c[4:0]};
            default: return {c[10:5], c[10:7]};
        endcase
    endfunction

    function automatic exp_t fexp(input int i, input logic [15:0] c);
        exp_t r;
        r.v = 1'b1;
        r.d = ref_px(c, i % 8, i / 8);
        r.s = (i == 0);
        r.e = ((i % 8) == 7);
        r.f = (i == 31);
        return r;
    endfunction

    function automatic logic [15:0] pat(input int i, input int seed);
        return 16'((i * 925) ^ (seed * 4661));
    endfunction

    // One clock of stimulus; outputs then belong to the previous step's pixel.
    task automatic step(input logic sof, input logic vld, input logic [15:0] din,
                        input exp_t e, input logic err);
        bus.sof_in         = sof;
        bus.pixel_in_valid = vld;
        bus.pixel_in_data  = din;
        @(posedge clk);
        #1;
        chk("frame_err", {31'd0, bus.frame_err}, {31'd0, err});
        chk("out_valid", {31'd0, bus.pixel_out_valid}, {31'd0, pend.v});
        chk("sof_out", {31'd0, bus.sof_out}, {31'd0, pend.s});
        chk("eol_out", {31'd0, bus.eol_out}, {31'd0, pend.e});
        chk("eof_out", {31'd0, bus.eof_out}, {31'd0, pend.f});
        if (pend.v && chk_data) chk("out_data", {22'd0, bus.pixel_out_data}, {22'd0, pend.d});
        if (bus.pixel_out_valid) begin
            n_out++;
            cap.push_back(bus.pixel_out_data);
        end
        pend = e;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 16'h0000, NONE, 1'b0);
    endtask

    // Frame pixels from..to; sof_in on pixel 0, spec vectors substituted by seed.
    task automatic run_px(input int seed, input bit gaps, input logic first_err,
                          input int from, input int to);
        for (int i = from; i <= to; i++) begin
            logic [15:0] c;
            exp_t        e;
            logic        hv;
            logic [9:0]  hd;
            c  = pat(i, seed);
            hv = 1'b0;
            hd = 10'd0;
            if (seed == 1 && i == 0) begin c = 16'h07E0; hv = 1'b1; hd = 10'h3FF; end
            if (seed == 1 && i == 1) begin c = 16'hF800; hv = 1'b1; hd = 10'h3FF; end
            if (seed == 1 && i == 8) begin c = 16'h001F; hv = 1'b1; hd = 10'h3FF; end
            if (seed == 2 && i == 8) begin c = 16'hF800; hv = 1'b1; hd = 10'h000; end
            e = fexp(i, c);
            if (hv) e.d = hd;
            step(i == 0, 1'b1, c, e, (i == 0) ? first_err : 1'b0);
            if (gaps) idle();
        end
    endtask

    task automatic run_const(input logic [15:0] c, input int n, input logic first_err);
        for (int i = 0; i < n; i++) begin
            step(i == 0, 1'b1, c, fexp(i, c), (i == 0) ? first_err : 1'b0);
        end
        idle();
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk(tag, {22'd0, bus.pixel_out_data, bus.pixel_out_valid, bus.sof_out,
                  bus.eol_out, bus.eof_out, bus.frame_err}, 32'd0);
    endtask

    initial begin
        reset_n            = 1'b0;
        bus.sof_in         = 1'b0;
        bus.pixel_in_valid = 1'b0;
        bus.pixel_in_data  = 16'h0000;
        #12;
        chk_zero_outputs("reset_outputs");
        @(negedge clk);
        reset_n = 1'b1;
        idle();

`ifndef BAYER_REMOSAIC_DITHER_EN
        // Full frames with spec vectors, then DONE -> ACTIVE on a new sof.
        n_out = 0;
        run_px(1, 1'b0, 1'b0, 0, 31);
        idle();
        chk("t1_count", n_out, 32);
        run_px(2, 1'b0, 1'b0, 0, 31);
        idle();

        // Valid toggling 1010...: pipe check enforces exact 2-cycle latency.
        n_out = 0;
        run_px(3, 1'b1, 1'b0, 0, 31);
        idle();
        chk("t2_count", n_out, 32);

        // Short frame: restart after 13 pixels.
        run_px(4, 1'b0, 1'b0, 0, 12);
        e0 = fexp(0, 16'hF800);
        e0.d = 10'h000;
        step(1'b1, 1'b1, 16'hF800, e0, 1'b1);
        e0 = fexp(1, 16'hF800);
        e0.d = 10'h3FF;
        step(1'b0, 1'b1, 16'hF800, e0, 1'b0);
        run_px(4, 1'b0, 1'b0, 2, 31);
        idle();

        // Stray pixels after eof: dropped, one error each.
        base = n_out;
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, pat(k, 9), NONE, 1'b1);
        idle();
        idle();
        chk("t4_no_out", n_out - base, 0);

        // Reset in the middle of a frame.
        run_px(5, 1'b0, 1'b0, 0, 9);
        bus.pixel_in_valid = 1'b0;
        bus.sof_in         = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk_zero_outputs("t5_reset_now");
        @(posedge clk);
        #1;
        chk_zero_outputs("t5_reset_hold");
        @(negedge clk);
        reset_n = 1'b1;
        pend = NONE;
        n_out = 0;
        run_px(6, 1'b0, 1'b0, 0, 31);
        idle();
        chk("t5_count", n_out, 32);
`else
        // Dither: bounded low bits, and a repeatable sequence per frame.
        chk_data = 1'b0;
        cap.delete();
        run_const(16'h0000, 8, 1'b0);
        for (int k = 0; k < 8; k++) begin
            chk("t6_low", {31'd0, (cap[k] <= (((k % 2) == 0) ? 10'h00F : 10'h01F))}, 32'd1);
        end
        cap.delete();
        run_const(16'hFFFF, 8, 1'b1);
        for (int k = 0; k < 8; k++) chk("t6_high", {31'd0, (cap[k] >= 10'h3E0)}, 32'd1);
        cap.delete();
        run_px(7, 1'b0, 1'b1, 0, 15);
        idle();
        seq_a = cap;
        cap.delete();
        run_px(7, 1'b0, 1'b1, 0, 15);
        idle();
        chk("t6_len", cap.size(), 16);
        for (int k = 0; k < 16; k++) chk("t6_repeat", {22'd0, cap[k]}, {22'd0, seq_a[k]});
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
